// File: rtl/bool_lut_eval.sv
// Programmable N-input boolean function: a 2^N_IN-entry truth table with a
// registered evaluate path and an autonomous sweep that streams every entry
// in ascending order and counts the entries that are 1.
module bool_lut_eval #(
  parameter int unsigned N_IN = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_we,
  input  logic [N_IN-1:0] cfg_addr,
  input  logic            cfg_bit,
  input  logic            in_valid,
  input  logic [N_IN-1:0] in_vec,
  input  logic            sweep_start,
  output logic            busy,
  output logic            out_valid,
  output logic            y,
  output logic [N_IN-1:0] out_addr,
  output logic [N_IN:0]   ones_count,
  output logic            sweep_done
);

  localparam int unsigned DEPTH = 1 << N_IN;
  localparam int unsigned CW    = N_IN + 1;

  // Counter is one bit wider than the address so the final entry compares
  // cleanly without wrap-around aliasing.
  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SWEEP = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [DEPTH-1:0] table_q, table_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    ones_q, ones_d;
  logic             busy_q, busy_d;
  logic             out_valid_q, out_valid_d;
  logic             y_q, y_d;
  logic [N_IN-1:0]  addr_q, addr_d;
  logic             done_q, done_d;

  // Next-state and next-output logic; reads use table_q so a same-edge
  // write and evaluate of one address returns the old entry.
  always_comb begin
    state_d     = state_q;
    table_d     = table_q;
    cnt_d       = cnt_q;
    ones_d      = ones_q;
    out_valid_d = 1'b0;
    y_d         = y_q;
    addr_d      = addr_q;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cfg_we) begin
          table_d[cfg_addr] = cfg_bit;
        end
        if (in_valid) begin
          out_valid_d = 1'b1;
          y_d         = table_q[in_vec];
          addr_d      = in_vec;
        end
        if (sweep_start) begin
          state_d = S_SWEEP;
          cnt_d   = '0;
          ones_d  = '0;
        end
      end
      S_SWEEP: begin
        out_valid_d = 1'b1;
        y_d         = table_q[cnt_q[N_IN-1:0]];
        addr_d      = cnt_q[N_IN-1:0];
        ones_d      = ones_q + CW'(table_q[cnt_q[N_IN-1:0]]);
        cnt_d       = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_SWEEP);
  end

  // State, table and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      table_q     <= '0;
      cnt_q       <= '0;
      ones_q      <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      y_q         <= 1'b0;
      addr_q      <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      table_q     <= table_d;
      cnt_q       <= cnt_d;
      ones_q      <= ones_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
      addr_q      <= addr_d;
      done_q      <= done_d;
    end
  end

  assign busy       = busy_q;
  assign out_valid  = out_valid_q;
  assign y          = y_q;
  assign out_addr   = addr_q;
  assign ones_count = ones_q;
  assign sweep_done = done_q;

endmodule

// File: doc/bool_lut_eval.md
Name: bool_lut_eval

Overview:
Parametrised successor to the fixed 5-input boolean-expression gate block. Implements any N-input boolean function as a programmable truth table (2^N_IN one-bit entries) with a registered evaluate path. An autonomous sweep mode walks every input combination, streams each result, and counts the minterms that evaluate to 1. It sits beside the combinational gate blocks as a reusable, reprogrammable expression engine and self-check source.

Parameters:
N_IN, 5, number of boolean inputs; the table holds 2^N_IN entries; legal range 1..8.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous, active-high reset.
cfg_we  input  1  truth-table write strobe.
cfg_addr  input  N_IN  table entry (input combination) to write.
cfg_bit  input  1  output value for cfg_addr.
in_valid  input  1  evaluate request.
in_vec  input  N_IN  input combination to evaluate.
sweep_start  input  1  start exhaustive sweep (pulse or level).
busy  output  1  sweep in progress.
out_valid  output  1  y/out_addr valid this cycle.
y  output  1  function value.
out_addr  output  N_IN  input combination that y belongs to.
ones_count  output  N_IN+1  number of 1-entries found by the last sweep.
sweep_done  output  1  one-cycle pulse with the final sweep result.

Behaviour:
- Reset (synchronous, rst high at an edge): all table entries = 0; FSM = IDLE; busy, out_valid, y, out_addr, ones_count, sweep_done = 0. Reset applies mid-sweep: the sweep aborts, busy=0 and no sweep_done after the reset edge.
- FSM states: IDLE and SWEEP. busy = (state==SWEEP), registered.
- Write: at an edge with cfg_we=1 and state IDLE, table[cfg_addr] <= cfg_bit. cfg_we in SWEEP is ignored (table frozen).
- Evaluate, latency 1: at an edge with in_valid=1 and state IDLE, out_valid<=1, y<=table[in_vec], out_addr<=in_vec. in_valid in SWEEP is dropped with no response and no backpressure. Back-to-back requests give one result per cycle.
- Read-before-write: when cfg_we and in_valid hit the same address on the same edge, y returns the old entry. The new value is visible from the next request.
- Sweep start: at an edge with sweep_start=1 and state IDLE, state<=SWEEP, the internal counter cnt<=0, and ones_count<=0. sweep_start while busy is ignored.
- SWEEP, each edge k = 1..2^N_IN after the start edge:
  - out_valid<=1, y<=table[cnt], out_addr<=cnt.
  - ones_count<=ones_count+table[cnt], then cnt<=cnt+1.
  - On the edge processing cnt=2^N_IN-1: sweep_done<=1 and state<=IDLE.
  - Result: busy is high for exactly 2^N_IN cycles, results arrive in ascending order, and sweep_done coincides with the last result.
  - cnt is N_IN+1 bits wide or compares before wrap, so no wrap-around aliasing.
- Same-edge sweep_start and in_valid in IDLE: both accepted. The eval result appears after the start edge; the first sweep result follows one cycle later. There is no collision.
- Outside accepted events, out_valid=0 and sweep_done=0. y and out_addr hold their last value. ones_count holds until the next sweep start or reset.
- Widths: ones_count max = 2^N_IN, which fits N_IN+1 bits (N_IN=5 gives 32 = 6'b100000).

Test Plan:
- Reset then evaluate: rst for 2 cycles, then in_vec=5'b10101 -> one cycle later out_valid=1, y=0, out_addr=5'b10101. All outputs are 0 during reset.
- Program and evaluate: write table[k]=k[0]^k[4] for all 32 k, then evaluate 01010, 10101, 00001, 10110, 01000 on consecutive cycles -> y = 0,0,1,1,0 respectively, each with 1-cycle latency and no gaps.
- Sweep: with the table above, pulse sweep_start -> busy high 32 cycles; out_addr runs 0..31 in order; sweep_done pulses with out_addr=31; ones_count=16. An all-ones table gives ones_count=32.
- Busy lockout: during the sweep, assert cfg_we (addr 3, bit flipped), in_valid, and sweep_start -> no extra results, table[3] unchanged on the next sweep, and the sweep length stays 32.
- Read-before-write: table[7]=0; same edge cfg_we addr 7 bit 1 and in_valid in_vec 7 -> y=0. Re-evaluating 7 next cycle -> y=1.
- Reset mid-sweep: rst at sweep cycle 10 -> busy=0, no sweep_done, ones_count=0, table all 0 (a following sweep returns ones_count=0).
